// File: rtl/lab03_pkg.sv
// Shared definitions for the instruction sequencer and its peers.
// Holds the sequencer state encoding and the instruction field positions
// that the datapath control unit and benches decode.
package lab03_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    FINISH,
    ERROR
  } seq_state_t;

  // Instruction field layout (bit positions within a 16-bit instruction)
  localparam int DST_MSB  = 15;
  localparam int DST_LSB  = 13;
  localparam int SRC_MSB  = 12;
  localparam int SRC_LSB  = 10;
  localparam int ALU_MSB  = 6;
  localparam int ALU_LSB  = 3;
  localparam int MODE_BIT = 2;

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer control bus: program load, run control, and the issue/done
// handshake with the datapath control unit.
//   master : the sequencer (drives instruction/run/status)
//   slave  : host + control unit (drives program load, start/abort, done)
interface instr_sequencer_if #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 16
);
  localparam int AW = $clog2(DEPTH);

  logic               prog_we;
  logic [AW-1:0]      prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic [AW:0]        prog_len;
  logic               start;
  logic               abort;
  logic               done;
  logic [INSTR_W-1:0] instruction;
  logic               run;
  logic [AW-1:0]      pc;
  logic               busy;
  logic               program_done;
  logic               error;
  logic [AW:0]        exec_count;

  modport master (
    input  prog_we, prog_addr, prog_data, prog_len, start, abort, done,
    output instruction, run, pc, busy, program_done, error, exec_count
  );

  modport slave (
    output prog_we, prog_addr, prog_data, prog_len, start, abort, done,
    input  instruction, run, pc, busy, program_done, error, exec_count
  );
endinterface

// File: rtl/instr_mem.sv
// Program memory: DEPTH x INSTR_W, synchronous write, combinational read.
//   clk     : write clock
//   we_i    : write strobe (already gated by the sequencer)
//   waddr_i : write address, wdata_i : write data
//   raddr_i : read address, rdata_o : read data (combinational)
// Contents are deliberately not reset.
module instr_mem #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [INSTR_W-1:0]       wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [INSTR_W-1:0]       rdata_o
);
  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: steps through a loaded program, presenting each
// instruction to the datapath control unit with a one-cycle run strobe
// and waiting for its done pulse. Flags a watchdog timeout and counts
// completed instructions.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : control bus (master side), see instr_sequencer_if
module instr_sequencer
  import lab03_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  instr_sequencer_if.master  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT);

  seq_state_t         state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [CW-1:0]      len_q, len_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WW-1:0]      wd_q, wd_d;
  logic               err_q, err_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] mem_rdata;
  logic [CW-1:0]      len_clamp;
  logic               busy;
  logic               last;

  assign busy      = (state_q == FETCH) || (state_q == ISSUE) || (state_q == WAIT);
  // Clamping the length keeps pc from ever wrapping past the last entry.
  assign len_clamp = (bus.prog_len > CW'(DEPTH)) ? CW'(DEPTH) : bus.prog_len;
  assign last      = ({1'b0, pc_q} == (len_q - CW'(1)));

  instr_mem #(.DEPTH(DEPTH), .INSTR_W(INSTR_W)) u_mem (
    .clk     (clk),
    .we_i    (bus.prog_we && !busy),
    .waddr_i (bus.prog_addr),
    .wdata_i (bus.prog_data),
    .raddr_i (pc_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    err_d   = err_q;
    instr_d = instr_q;
    case (state_q)
      IDLE, ERROR: begin
        if (bus.start) begin
          len_d   = len_clamp;
          err_d   = 1'b0;
          cnt_d   = '0;
          pc_d    = '0;
          state_d = (len_clamp == '0) ? FINISH : FETCH;
        end else if (state_q == ERROR && bus.abort) begin
          state_d = IDLE;  // error stays set until the next start
        end
      end
      FETCH: begin
        if (bus.abort) state_d = IDLE;
        else begin
          instr_d = mem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.abort) state_d = IDLE;
        else begin
          wd_d    = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // abort outranks a coincident done, so the count is not bumped
        if (bus.abort) state_d = IDLE;
        else if (bus.done) begin
          cnt_d = cnt_q + CW'(1);
          if (last) state_d = FINISH;
          else begin
            pc_d    = pc_q + AW'(1);
            state_d = FETCH;
          end
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // run and program_done are decoded from state so reset kills them at once;
  // abort suppresses them in the same cycle.
  assign bus.instruction  = instr_q;
  assign bus.run          = (state_q == ISSUE) && !bus.abort;
  assign bus.pc           = pc_q;
  assign bus.busy         = busy;
  assign bus.program_done = (state_q == FINISH) && !bus.abort;
  assign bus.error        = err_q;
  assign bus.exec_count   = cnt_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected run /
// program_done / error events with their cycle; a monitor pops and compares.
module tb_instr_sequencer;
  localparam int DEPTH   = 16;
  localparam int INSTR_W = 16;
  localparam int TIMEOUT = 64;
  localparam int EV_RUN = 0, EV_PDONE = 1, EV_ERR = 2;

  typedef struct {
    int          kind;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  logic clk = 0;
  logic reset = 1;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  ev_t  exp_q[$];
  logic [15:0] model [DEPTH];
  bit   resp_en = 1;
  int   run_n = 0;
  int   abort_at = -1;
  logic err_prev = 0;

  instr_sequencer_if #(.DEPTH(DEPTH), .INSTR_W(INSTR_W)) bus ();

  instr_sequencer #(.DEPTH(DEPTH), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, required %0h (cyc %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic push(input int k, input logic [15:0] d, input int c);
    ev_t e;
    e.kind = k; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int k, input logic [15:0] d, input string nm);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: unexpected event data %0h at cyc %0d, required none", nm, d, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.data !== d || e.cyc != cyc)
      $display("FAIL %s: got kind %0d data %0h cyc %0d, required kind %0d data %0h cyc %0d",
               nm, k, d, cyc, e.kind, e.data, e.cyc);
    else n_pass++;
  endtask

  // Monitor: every observable event must match the head of the queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.run) check_ev(EV_RUN, bus.instruction, "run");
      if (bus.program_done) check_ev(EV_PDONE, 16'(bus.exec_count), "program_done");
      if (bus.error && !err_prev) check_ev(EV_ERR, 16'h0, "error_rise");
    end
    err_prev = bus.error;
  end

  // Control-unit model: done two cycles after run, optional abort with done.
  initial begin
    bus.done = 0;
    bus.abort = 0;
    forever begin
      @(negedge clk);
      if (bus.run && resp_en && !reset) begin
        run_n++;
        repeat (2) @(negedge clk);
        bus.done = 1;
        if (run_n == abort_at) bus.abort = 1;
        @(negedge clk);
        bus.done = 0;
        bus.abort = 0;
      end
    end
  end

  task automatic load(input logic [3:0] a, input logic [15:0] d, input bit upd);
    bus.prog_we = 1; bus.prog_addr = a; bus.prog_data = d;
    @(negedge clk);
    bus.prog_we = 0;
    if (upd) model[a] = d;
  endtask

  // Start a program; runs are expected every 4 cycles with the 2-cycle responder.
  task automatic run_prog(input logic [4:0] len, input int nr, input bit pd,
                          input logic [4:0] cnt, output int t);
    @(negedge clk);
    bus.prog_len = len; bus.start = 1; t = cyc;
    for (int i = 0; i < nr; i++) push(EV_RUN, model[i], t + 2 + 4 * i);
    if (pd) push(EV_PDONE, 16'(cnt), t + 4 * nr + 1);
    @(negedge clk);
    bus.start = 0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s: %0d events still pending, required 0", nm, exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int t;
    bus.prog_we = 0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.prog_len = '0; bus.start = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_instruction", bus.instruction, 0);
    chk("rst_run", bus.run, 0);
    chk("rst_pc", bus.pc, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_program_done", bus.program_done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_exec_count", bus.exec_count, 0);

    // three-instruction program
    load(0, 16'h2448, 1);
    load(1, 16'h4A10, 1);
    load(2, 16'hE01C, 1);
    run_prog(3, 3, 1, 3, t);
    wait_idle("prog3", 200);
    chk("prog3_pc", bus.pc, 2);
    chk("prog3_exec_count", bus.exec_count, 3);

    // writing mem[pc] in IDLE leaves the held instruction alone
    load(2, 16'h5555, 1);
    chk("idle_write_hold", bus.instruction, 16'hE01C);

    // empty program
    run_prog(0, 0, 1, 0, t);
    chk("len0_busy", bus.busy, 0);
    wait_idle("len0", 20);

    // full memory, length clamped from 20 to 16
    for (int i = 0; i < DEPTH; i++) load(4'(i), 16'h1000 + 16'(i) * 16'h0111, 1);
    run_prog(20, 16, 1, 16, t);
    wait_idle("clamp", 300);
    chk("clamp_pc", bus.pc, 15);

    // watchdog: no done at all
    resp_en = 0;
    run_prog(1, 1, 0, 0, t);
    push(EV_ERR, 16'h0, t + 2 + TIMEOUT + 1);
    wait_idle("watchdog", 200);
    chk("err_busy", bus.busy, 0);
    chk("err_flag", bus.error, 1);
    resp_en = 1;
    run_prog(1, 1, 1, 1, t);
    chk("restart_clears_error", bus.error, 0);
    wait_idle("restart", 50);

    // abort coincident with done on the 2nd instruction
    abort_at = run_n + 2;
    run_prog(3, 2, 0, 0, t);
    while (cyc < t + 9) @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_exec_count", bus.exec_count, 1);
    chk("abort_pc", bus.pc, 1);
    repeat (6) @(negedge clk);
    wait_idle("abort", 10);
    abort_at = -1;

    // write while busy is dropped; rerun shows original word
    run_prog(1, 1, 1, 1, t);
    load(0, 16'hDEAD, 0);
    wait_idle("busy_write_run", 50);
    run_prog(1, 1, 1, 1, t);
    wait_idle("busy_write_rerun", 50);

    // async reset during ISSUE of the 2nd instruction
    run_prog(3, 2, 0, 0, t);
    while (cyc < t + 6) @(negedge clk);
    #2;
    chk("pre_reset_pc", bus.pc, 1);
    reset = 1;
    #1;
    chk("async_run", bus.run, 0);
    chk("async_pc", bus.pc, 0);
    chk("async_busy", bus.busy, 0);
    chk("async_exec_count", bus.exec_count, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (5) @(negedge clk);
    wait_idle("reset_mid_run", 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
